// File: rtl/dcm_pos_sched.sv
// dcm_pos_sched
//   Folds counted motor pulses into a shared position register file. Pulses
//   accumulate in small per-channel pending counters. A round-robin scheduler
//   then performs a read-modify-write of the selected channel's position word
//   (IDLE -> RD -> CALC -> WR). An SPI host can claim the register file
//   between updates, and it takes priority over pending work.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   pulse_evt  per-channel one-cycle pulse strobes
//   dir        per-channel direction (1 = decrement, 0 = increment)
//   host_req   host requests the register file
//   host_gnt   host owns the register file
//   rf_addr    channel index of the accessed position word
//   rf_rd      read strobe (rf_rdata valid one cycle later)
//   rf_rdata   position read data
//   rf_we      write strobe
//   rf_wdata   updated position
//   upd_valid  update strobe, coincident with rf_we
//   upd_chan   channel of the update
//   ovf        sticky pending-counter overflow flags
//   ovf_clr    per-channel clear of ovf
module dcm_pos_sched #(
  parameter int NCH   = 6,
  parameter int PW    = 24,
  parameter int PENDW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   pulse_evt,
  input  logic [NCH-1:0]   dir,
  input  logic             host_req,
  output logic             host_gnt,
  output logic [2:0]       rf_addr,
  output logic             rf_rd,
  input  logic [PW-1:0]    rf_rdata,
  output logic             rf_we,
  output logic [PW-1:0]    rf_wdata,
  output logic             upd_valid,
  output logic [2:0]       upd_chan,
  output logic [NCH-1:0]   ovf,
  input  logic [NCH-1:0]   ovf_clr
);

  typedef enum logic [2:0] {IDLE, HOST, RD, CALC, WR} state_t;

  localparam logic [PENDW-1:0] PEND_MAX = '1;

  state_t           state, next_state;
  logic [PENDW-1:0] pend [NCH];
  logic [2:0]       last_grant;
  logic [2:0]       ch;
  logic [PENDW-1:0] delta;
  logic             dir_q;
  logic [2:0]       sel_ch;
  logic             sel_found;
  logic             grant;
  logic [PW-1:0]    newpos;

  logic             host_gnt_d, rf_rd_d, rf_we_d;
  logic [2:0]       rf_addr_d, upd_chan_d;
  logic [PW-1:0]    rf_wdata_d;

  // Round-robin search: scan from the channel after the last grant and take
  // the first one with pulses pending.
  always_comb begin
    logic [2:0] idx;
    idx       = '0;
    sel_ch    = last_grant;
    sel_found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = 3'((int'(last_grant) + k) % NCH);
      if (!sel_found && pend[idx] != '0) begin
        sel_ch    = idx;
        sel_found = 1'b1;
      end
    end
  end

  // Next-state logic. The host only wins from IDLE, so an update that has
  // already started always runs to completion.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (host_req)       next_state = HOST;
               else if (sel_found) next_state = RD;
      HOST:    if (!host_req)      next_state = IDLE;
      RD:      next_state = CALC;
      CALC:    next_state = WR;
      WR:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign grant = (state == IDLE) && (next_state == RD);

  // State register plus the channel, delta and direction captured at grant.
  // Direction is frozen here, so later changes of dir cannot affect this update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 3'(NCH - 1);
      ch         <= '0;
      delta      <= '0;
      dir_q      <= 1'b0;
    end else begin
      state <= next_state;
      if (grant) begin
        ch         <= sel_ch;
        delta      <= pend[sel_ch];
        dir_q      <= dir[sel_ch];
        last_grant <= sel_ch;
      end
    end
  end

  // Pending counters. On the grant edge the granted counter restarts from that
  // cycle's pulse so that the pulse is not lost. A pulse into a full counter
  // is dropped and flagged. A set wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) pend[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (grant && sel_ch == 3'(i)) begin
          pend[i] <= PENDW'(pulse_evt[i]);
        end else if (pulse_evt[i] && pend[i] != PEND_MAX) begin
          pend[i] <= pend[i] + PENDW'(1);
        end
        if (pulse_evt[i] && pend[i] == PEND_MAX && !(grant && sel_ch == 3'(i)))
          ovf[i] <= 1'b1;
        else if (ovf_clr[i])
          ovf[i] <= 1'b0;
      end
    end
  end

  // Read data arrives during CALC; the result wraps modulo 2^PW.
  assign newpos = dir_q ? (rf_rdata - PW'(delta)) : (rf_rdata + PW'(delta));

  // Output decode from the upcoming state. The registered copies then line up
  // exactly with the state they belong to.
  always_comb begin
    host_gnt_d = (next_state == HOST);
    rf_rd_d    = (next_state == RD);
    rf_we_d    = (next_state == WR);
    rf_addr_d  = grant ? sel_ch : rf_addr;
    upd_chan_d = (state == CALC) ? ch : upd_chan;
    rf_wdata_d = (state == CALC) ? newpos : rf_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_gnt  <= 1'b0;
      rf_rd     <= 1'b0;
      rf_we     <= 1'b0;
      upd_valid <= 1'b0;
      rf_addr   <= '0;
      rf_wdata  <= '0;
      upd_chan  <= '0;
    end else begin
      host_gnt  <= host_gnt_d;
      rf_rd     <= rf_rd_d;
      rf_we     <= rf_we_d;
      upd_valid <= rf_we_d;
      rf_addr   <= rf_addr_d;
      rf_wdata  <= rf_wdata_d;
      upd_chan  <= upd_chan_d;
    end
  end

endmodule

// File: tb/tb_dcm_pos_sched.sv
module tb_dcm_pos_sched;

  localparam int NCH   = 6;
  localparam int PW    = 24;
  localparam int PENDW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] pulse_evt;
  logic [NCH-1:0] dir;
  logic           host_req;
  logic           host_gnt;
  logic [2:0]     rf_addr;
  logic           rf_rd;
  logic [PW-1:0]  rf_rdata;
  logic           rf_we;
  logic [PW-1:0]  rf_wdata;
  logic           upd_valid;
  logic [2:0]     upd_chan;
  logic [NCH-1:0] ovf;
  logic [NCH-1:0] ovf_clr;

  int vectors     = 0;
  int miscompares = 0;

  // Position register file model, plus a loader port the bench uses for preloads
  logic [PW-1:0] mem [8];
  logic          loadEn = 1'b0;
  logic [2:0]    loadAddr = '0;
  logic [PW-1:0] loadData = '0;

  typedef struct {
    int            chan;
    logic          dirv;
    int            npulses;
    logic [PW-1:0] init;
    logic [PW-1:0] expData;
  } vec_t;

  vec_t vecs [6];

  dcm_pos_sched #(.NCH(NCH), .PW(PW), .PENDW(PENDW)) dut (
    .clk(clk), .reset(reset), .pulse_evt(pulse_evt), .dir(dir),
    .host_req(host_req), .host_gnt(host_gnt), .rf_addr(rf_addr),
    .rf_rd(rf_rd), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .upd_valid(upd_valid), .upd_chan(upd_chan), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Register file with one-cycle read latency
  always @(posedge clk) begin
    if (rf_rd) rf_rdata <= mem[rf_addr];
    if (rf_we) mem[rf_addr] <= rf_wdata;
    if (loadEn) mem[loadAddr] <= loadData;
  end

  // Bus exclusivity watch: no strobes while the host is granted, and never both
  always @(negedge clk) begin
    if (reset === 1'b1 && ((host_gnt && (rf_rd || rf_we)) || (rf_rd && rf_we))) begin
      miscompares++;
      $display("[TB] FAIL bus_excl: got host_gnt=%0b rf_rd=%0b rf_we=%0b, required no strobe while granted and never both",
               host_gnt, rf_rd, rf_we);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic loadMem(input int a, input logic [PW-1:0] d);
    loadEn = 1'b1;
    loadAddr = 3'(a);
    loadData = d;
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    pulse_evt = '0;
    host_req = 1'b0;
    ovf_clr = '0;
    dir = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulseChan(input int c, input int n);
    for (int p = 0; p < n; p++) begin
      pulse_evt[c] = 1'b1;
      @(negedge clk);
    end
    pulse_evt = '0;
  endtask

  // Claim the bus and wait (bounded) for the grant
  task automatic hostGrab();
    logic got;
    got = 1'b0;
    host_req = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (host_gnt) got = 1'b1;
    end
    if (!got) checkOutput("host_gnt_wait", 32'(got), 32'd1);
  endtask

  // Bounded wait for the next write; optionally flips dir[c] once the read starts
  task automatic waitWrite(output int lat, output logic seen, input logic flipDir, input int c);
    logic flipped;
    flipped = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      lat++;
      if (rf_rd && flipDir && !flipped) begin
        dir[c] = ~dir[c];
        flipped = 1'b1;
      end
      if (rf_we) seen = 1'b1;
    end
  endtask

  // Accumulate a vector's pulses while the host holds the bus, then release and check the update
  task automatic applyStimulus(input int i, input vec_t v);
    int   lat;
    logic seen;
    loadMem(v.chan, v.init);
    hostGrab();
    dir[v.chan] = ~v.dirv;
    pulseChan(v.chan, v.npulses);
    dir[v.chan] = v.dirv;
    host_req = 1'b0;
    waitWrite(lat, seen, 1'b1, v.chan);
    checkOutput($sformatf("v%0d_we_seen", i), 32'(seen), 32'd1);
    checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
    checkOutput($sformatf("v%0d_addr", i), 32'(rf_addr), 32'(v.chan));
    checkOutput($sformatf("v%0d_wdata", i), 32'(rf_wdata), 32'(v.expData));
    checkOutput($sformatf("v%0d_upd_valid", i), 32'(upd_valid), 32'd1);
    checkOutput($sformatf("v%0d_upd_chan", i), 32'(upd_chan), 32'(v.chan));
    checkOutput($sformatf("v%0d_ovf", i), 32'(ovf), 32'd0);
    @(negedge clk);
    dir = '0;
  endtask

  initial begin
    int            lat;
    logic          seen;
    logic          found;
    int            wcnt, cyc;
    int            wch [4];
    int            wcyc [4];
    logic [PW-1:0] wdat [4];
    int            expCh [4];
    logic [PW-1:0] expDat [4];
    int            cntRd, cntWe;

    vecs[0] = '{0, 1'b0, 3, 24'd500,     24'd503};
    vecs[1] = '{2, 1'b1, 1, 24'h000000,  24'hFFFFFF};
    vecs[2] = '{2, 1'b0, 2, 24'hFFFFFF,  24'h000001};
    vecs[3] = '{3, 1'b1, 5, 24'd1000,    24'd995};
    vecs[4] = '{5, 1'b0, 7, 24'h123456,  24'h12345D};
    vecs[5] = '{1, 1'b1, 7, 24'h000003,  24'hFFFFFC};

    reset = 1'b0;
    pulse_evt = '0;
    dir = '0;
    host_req = 1'b0;
    ovf_clr = '0;
    repeat (2) @(negedge clk);

    // Reset values
    checkOutput("rst_host_gnt", 32'(host_gnt), 32'd0);
    checkOutput("rst_rf_rd", 32'(rf_rd), 32'd0);
    checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
    checkOutput("rst_upd_valid", 32'(upd_valid), 32'd0);
    checkOutput("rst_rf_addr", 32'(rf_addr), 32'd0);
    checkOutput("rst_rf_wdata", 32'(rf_wdata), 32'd0);
    checkOutput("rst_upd_chan", 32'(upd_chan), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven single-channel updates, including wrap in both directions
    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    // Round-robin after reset: 1, 3, 5, then a fresh ch1 pulse after ch5
    doReset();
    loadMem(1, 24'd100);
    loadMem(3, 24'd300);
    loadMem(5, 24'd500);
    hostGrab();
    pulse_evt = 6'b101010;
    @(negedge clk);
    pulse_evt = '0;
    host_req = 1'b0;
    wcnt = 0;
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      wch[k] = -1;
      wcyc[k] = -1;
      wdat[k] = '0;
    end
    for (int t = 0; t < 60 && wcnt < 4; t++) begin
      @(negedge clk);
      cyc++;
      pulse_evt = '0;
      if (rf_we) begin
        wch[wcnt] = int'(rf_addr);
        wdat[wcnt] = rf_wdata;
        wcyc[wcnt] = cyc;
        wcnt++;
        if (wcnt == 1) pulse_evt[1] = 1'b1;
      end
    end
    pulse_evt = '0;
    expCh = '{1, 3, 5, 1};
    expDat = '{24'd101, 24'd301, 24'd501, 24'd102};
    checkOutput("rr_count", 32'(wcnt), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rr_ch%0d", k), 32'(wch[k]), 32'(expCh[k]));
      checkOutput($sformatf("rr_data%0d", k), 32'(wdat[k]), 32'(expDat[k]));
    end
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("rr_spacing%0d", k), 32'(wcyc[k+1] - wcyc[k]), 32'd4);
    repeat (2) @(negedge clk);

    // Host request during CALC: write completes, host then wins over pending ch0
    loadMem(3, 24'd700);
    loadMem(0, 24'd50);
    pulseChan(3, 1);
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (rf_rd) found = 1'b1;
    end
    checkOutput("hp_rd_seen", 32'(found), 32'd1);
    @(negedge clk);
    host_req = 1'b1;
    pulse_evt[0] = 1'b1;
    @(negedge clk);
    pulse_evt = '0;
    checkOutput("hp_wr_we", 32'(rf_we), 32'd1);
    checkOutput("hp_wr_data", 32'(rf_wdata), 32'd701);
    checkOutput("hp_wr_gnt", 32'(host_gnt), 32'd0);
    @(negedge clk);
    checkOutput("hp_idle_gnt", 32'(host_gnt), 32'd0);
    checkOutput("hp_idle_rd", 32'(rf_rd), 32'd0);
    @(negedge clk);
    checkOutput("hp_gnt", 32'(host_gnt), 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("hp_gnt_held", 32'(host_gnt), 32'd1);
    host_req = 1'b0;
    waitWrite(lat, seen, 1'b0, 0);
    checkOutput("hp_resume_seen", 32'(seen), 32'd1);
    checkOutput("hp_resume_lat", 32'(lat), 32'd4);
    checkOutput("hp_resume_addr", 32'(rf_addr), 32'd0);
    checkOutput("hp_resume_data", 32'(rf_wdata), 32'd51);
    @(negedge clk);

    // Saturation on ch4 with the host holding the bus
    loadMem(4, 24'd1000);
    hostGrab();
    pulseChan(4, 7);
    checkOutput("sat_ovf_at_max", 32'(ovf), 32'd0);
    pulseChan(4, 2);
    checkOutput("sat_ovf_set", 32'(ovf), 32'h10);
    pulse_evt[4] = 1'b1;
    ovf_clr[4] = 1'b1;
    @(negedge clk);
    pulse_evt = '0;
    ovf_clr = '0;
    checkOutput("sat_set_beats_clr", 32'(ovf), 32'h10);
    host_req = 1'b0;
    waitWrite(lat, seen, 1'b0, 4);
    checkOutput("sat_we_seen", 32'(seen), 32'd1);
    checkOutput("sat_addr", 32'(rf_addr), 32'd4);
    checkOutput("sat_data", 32'(rf_wdata), 32'd1007);
    checkOutput("sat_ovf_sticky", 32'(ovf), 32'h10);
    ovf_clr[4] = 1'b1;
    @(negedge clk);
    ovf_clr = '0;
    checkOutput("sat_ovf_cleared", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);

    // Reset while in RD: update discarded, pend and ovf lost
    loadMem(2, 24'd40);
    hostGrab();
    pulseChan(4, 8);
    pulseChan(2, 1);
    checkOutput("rr_pre_ovf", 32'(ovf), 32'h10);
    host_req = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (rf_rd) found = 1'b1;
    end
    checkOutput("rrd_rd_seen", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rrd_async_rd", 32'(rf_rd), 32'd0);
    checkOutput("rrd_async_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cntRd = 0;
    cntWe = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rf_rd) cntRd++;
      if (rf_we) cntWe++;
    end
    checkOutput("rrd_no_write", 32'(cntWe), 32'd0);
    checkOutput("rrd_no_read", 32'(cntRd), 32'd0);
    checkOutput("rrd_ovf_after", 32'(ovf), 32'd0);
    checkOutput("rrd_mem_kept", 32'(mem[2]), 32'd40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
